// File: rtl/mic_pkg.sv
// rtl/mic_pkg.sv - shared microphone constants and clap FSM state encoding
package mic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOUD    = 2'd1,
        ST_HOLDOFF = 2'd2
    } clap_state_e;

    localparam int unsigned DEF_WIN_LOG2  = 8;
    localparam int unsigned DEF_THRESH_HI = 40;
    localparam int unsigned DEF_THRESH_LO = 20;
    localparam int unsigned DEF_MAX_LOUD  = 200;
    localparam int unsigned DEF_HOLDOFF   = 2000;

endpackage

// File: rtl/pdm_window_accum.sv
// rtl/pdm_window_accum.sv - PDM capture and per-window loudness decimation
module pdm_window_accum
    import mic_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = DEF_WIN_LOG2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic                pdm_clk,
    input  logic                pdm_data,
    output logic                win_done,
    output logic [WIN_LOG2-1:0] amplitude,
    output logic [WIN_LOG2-1:0] level,
    output logic                level_valid
);

    // Half-scale ones count: the density of a silent (50 %) PDM stream.
    localparam logic [WIN_LOG2:0] HALF = (WIN_LOG2 + 1)'(1 << (WIN_LOG2 - 1));

    logic                pclk_s1_q, pclk_s1_d;
    logic                pclk_s2_q, pclk_s2_d;
    logic                pclk_prev_q, pclk_prev_d;
    logic                data_s1_q, data_s1_d;
    logic                data_s2_q, data_s2_d;
    logic [WIN_LOG2-1:0] samp_q, samp_d;
    logic [WIN_LOG2:0]   ones_q, ones_d;
    logic [WIN_LOG2-1:0] level_q, level_d;
    logic                level_valid_q, level_valid_d;
    logic                tick;
    logic [WIN_LOG2:0]   ones_final;
    logic [WIN_LOG2:0]   diff;

    // Synchronisers, tick detect, window counting and amplitude of the closing window.
    always_comb begin
        pclk_s1_d   = pdm_clk;
        pclk_s2_d   = pclk_s1_q;
        pclk_prev_d = pclk_s2_q;
        data_s1_d   = pdm_data;
        data_s2_d   = data_s1_q;

        tick       = pclk_s2_q & ~pclk_prev_q;
        ones_final = ones_q + {{WIN_LOG2{1'b0}}, data_s2_q};
        diff       = (ones_final >= HALF) ? (ones_final - HALF) : (HALF - ones_final);
        amplitude  = diff[WIN_LOG2-1:0];
        // Disable overrides a window that completes on the same cycle.
        win_done   = enable & tick & (samp_q == '1);

        samp_d = samp_q;
        ones_d = ones_q;
        if (!enable) begin
            samp_d = '0;
            ones_d = '0;
        end else if (tick) begin
            samp_d = samp_q + WIN_LOG2'(1);
            ones_d = win_done ? '0 : ones_final;
        end

        level_d       = win_done ? amplitude : level_q;
        level_valid_d = win_done;
    end

    // State registers; level survives a disable, only reset clears it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pclk_s1_q     <= 1'b0;
            pclk_s2_q     <= 1'b0;
            pclk_prev_q   <= 1'b0;
            data_s1_q     <= 1'b0;
            data_s2_q     <= 1'b0;
            samp_q        <= '0;
            ones_q        <= '0;
            level_q       <= '0;
            level_valid_q <= 1'b0;
        end else begin
            pclk_s1_q     <= pclk_s1_d;
            pclk_s2_q     <= pclk_s2_d;
            pclk_prev_q   <= pclk_prev_d;
            data_s1_q     <= data_s1_d;
            data_s2_q     <= data_s2_d;
            samp_q        <= samp_d;
            ones_q        <= ones_d;
            level_q       <= level_d;
            level_valid_q <= level_valid_d;
        end
    end

    assign level       = level_q;
    assign level_valid = level_valid_q;

endmodule

// File: rtl/pdm_clap_detector.sv
// rtl/pdm_clap_detector.sv - clap detection FSM with hysteresis, noise reject and hold-off
module pdm_clap_detector
    import mic_pkg::*;
#(
    parameter int unsigned WIN_LOG2  = DEF_WIN_LOG2,
    parameter int unsigned THRESH_HI = DEF_THRESH_HI,
    parameter int unsigned THRESH_LO = DEF_THRESH_LO,
    parameter int unsigned MAX_LOUD  = DEF_MAX_LOUD,
    parameter int unsigned HOLDOFF   = DEF_HOLDOFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_mike,
    input  logic                pulse_2dot5MHz,
    input  logic                M_DATA,
    output logic [WIN_LOG2-1:0] level,
    output logic                level_valid,
    output logic                clap,
    output logic                busy
);

    // loud_cnt saturates at MAX_LOUD+1, hold_cnt tops out at HOLDOFF-1.
    localparam int unsigned LOUD_W = $clog2(MAX_LOUD + 2);
    localparam int unsigned HOLD_W = $clog2(HOLDOFF + 1);

    clap_state_e         state_q, state_d;
    logic [LOUD_W-1:0]   loud_q, loud_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                clap_q, clap_d;
    logic                busy_q, busy_d;
    logic                win_done;
    logic [WIN_LOG2-1:0] amplitude;
    logic [31:0]         amp_ext;

    pdm_window_accum #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_accum (
        .clk         (clk),
        .resetn      (reset),
        .enable      (enable_mike),
        .pdm_clk     (pulse_2dot5MHz),
        .pdm_data    (M_DATA),
        .win_done    (win_done),
        .amplitude   (amplitude),
        .level       (level),
        .level_valid (level_valid)
    );

    // Next state: the FSM only moves on a window-complete cycle; disable forces IDLE.
    always_comb begin
        state_d = state_q;
        loud_d  = loud_q;
        hold_d  = hold_q;
        clap_d  = 1'b0;
        amp_ext = 32'(amplitude);

        if (!enable_mike) begin
            state_d = ST_IDLE;
            loud_d  = '0;
            hold_d  = '0;
        end else if (win_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (amp_ext >= THRESH_HI) begin
                        state_d = ST_LOUD;
                        loud_d  = LOUD_W'(1);
                    end
                end
                ST_LOUD: begin
                    if (amp_ext < THRESH_LO) begin
                        // Episodes longer than MAX_LOUD windows are noise, not claps.
                        clap_d  = (32'(loud_q) <= MAX_LOUD);
                        state_d = ST_HOLDOFF;
                        loud_d  = '0;
                        hold_d  = '0;
                    end else if (32'(loud_q) <= MAX_LOUD) begin
                        loud_d = loud_q + LOUD_W'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (32'(hold_q) == HOLDOFF - 1) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // FSM state, counters and registered strobes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            loud_q  <= '0;
            hold_q  <= '0;
            clap_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            loud_q  <= loud_d;
            hold_q  <= hold_d;
            clap_q  <= clap_d;
            busy_q  <= busy_d;
        end
    end

    assign clap = clap_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_pdm_clap_detector.sv
// tb/tb_pdm_clap_detector.sv - self-checking bench for pdm_clap_detector
module tb_pdm_clap_detector;

    localparam int W    = 4;
    localparam int NWIN = 16;
    localparam int HI   = 5;
    localparam int LO   = 3;
    localparam int MAXL = 3;
    localparam int HOLD = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable_mike = 1'b0;
    logic         pulse = 1'b0;
    logic         mdata = 1'b0;
    logic [W-1:0] level;
    logic         level_valid;
    logic         clap;
    logic         busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int lvl;
        bit clp;
        bit bsy;
    } exp_t;

    typedef struct {
        int n_ones;
        int exp_level;
        bit exp_clap;
        bit exp_busy;
    } vec_t;

    exp_t expq[$];
    vec_t vecs[$];

    int m_loud_len = 0;
    int m_hold_left = 0;

    pdm_clap_detector #(
        .WIN_LOG2  (W),
        .THRESH_HI (HI),
        .THRESH_LO (LO),
        .MAX_LOUD  (MAXL),
        .HOLDOFF   (HOLD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable_mike    (enable_mike),
        .pulse_2dot5MHz (pulse),
        .M_DATA         (mdata),
        .level          (level),
        .level_valid    (level_valid),
        .clap           (clap),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int lvl, input bit c, input bit b);
        exp_t e;
        e.lvl = lvl;
        e.clp = c;
        e.bsy = b;
        expq.push_back(e);
    endtask

    // Every level_valid is matched against the next expected window result.
    always @(negedge clk) begin
        exp_t e;
        if (level_valid) begin
            if (expq.size() == 0) begin
                chk("unexpected_level_valid", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("level", int'(level), e.lvl);
                chk("clap", int'(clap), int'(e.clp));
                chk("busy", int'(busy), int'(e.bsy));
            end
        end else if (clap) begin
            chk("clap_without_level_valid", 1, 0);
        end
    end

    task automatic send_sample(input bit d);
        mdata = d;
        pulse = 1'b1;
        repeat (4) @(negedge clk);
        pulse = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Spreads n ones evenly over the window; n = half gives strict alternation.
    task automatic send_window(input int n);
        for (int i = 0; i < NWIN; i++) begin
            send_sample((((i + 1) * n) / NWIN - (i * n) / NWIN) != 0);
        end
    endtask

    task automatic model_clear();
        m_loud_len = 0;
        m_hold_left = 0;
    endtask

    // Episode-level view: a loud run length and a count of hold-off windows still to ignore.
    task automatic model_window(input int n);
        int a;
        bit c;
        a = (n >= NWIN / 2) ? n - NWIN / 2 : NWIN / 2 - n;
        c = 1'b0;
        if (m_hold_left > 0) begin
            m_hold_left--;
        end else if (m_loud_len > 0) begin
            if (a < LO) begin
                c = (m_loud_len <= MAXL);
                m_loud_len = 0;
                m_hold_left = HOLD;
            end else begin
                m_loud_len++;
            end
        end else if (a >= HI) begin
            m_loud_len = 1;
        end
        push_exp(a, c, (m_loud_len > 0) || (m_hold_left > 0));
    endtask

    task automatic add_vec(input int n, input int lvl, input bit c, input bit b);
        vec_t v;
        v.n_ones = n;
        v.exp_level = lvl;
        v.exp_clap = c;
        v.exp_busy = b;
        vecs.push_back(v);
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int r;

        // silence
        for (int i = 0; i < 4; i++) add_vec(8, 0, 0, 0);
        // between thresholds while idle: stays idle
        add_vec(12, 4, 0, 0);
        // single clap, loud window ignored in hold-off, then idle
        add_vec(16, 8, 0, 1);
        add_vec(16, 8, 0, 1);
        add_vec(8, 0, 1, 1);
        add_vec(16, 8, 0, 1);
        add_vec(8, 0, 0, 1);
        add_vec(8, 0, 0, 0);
        // hysteresis: exactly THRESH_HI enters, exactly THRESH_LO holds, exactly MAX_LOUD claps
        add_vec(13, 5, 0, 1);
        add_vec(12, 4, 0, 1);
        add_vec(11, 3, 0, 1);
        add_vec(10, 2, 1, 1);
        add_vec(8, 0, 0, 1);
        add_vec(8, 0, 0, 1);
        add_vec(8, 0, 0, 0);
        // sustained noise: MAX_LOUD+1 loud windows, no clap
        add_vec(3, 5, 0, 1);
        add_vec(16, 8, 0, 1);
        add_vec(0, 8, 0, 1);
        add_vec(16, 8, 0, 1);
        add_vec(8, 0, 0, 1);
        add_vec(8, 0, 0, 1);
        add_vec(8, 0, 0, 1);
        add_vec(8, 0, 0, 0);

        enable_mike = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_level", int'(level), 0);
        chk("reset_level_valid", int'(level_valid), 0);
        chk("reset_clap", int'(clap), 0);
        chk("reset_busy", int'(busy), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        foreach (vecs[i]) begin
            push_exp(vecs[i].exp_level, vecs[i].exp_clap, vecs[i].exp_busy);
            send_window(vecs[i].n_ones);
        end

        // enable drop mid-LOUD discards the episode
        push_exp(8, 0, 1);
        send_window(16);
        enable_mike = 1'b0;
        repeat (10) @(negedge clk);
        chk("endrop_busy", int'(busy), 0);
        chk("endrop_level_hold", int'(level), 8);
        chk("endrop_level_valid", int'(level_valid), 0);
        enable_mike = 1'b1;
        push_exp(0, 0, 0);
        send_window(8);

        // reset mid-window: partial window is lost
        for (int i = 0; i < 6; i++) send_sample(1'b1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midreset_level", int'(level), 0);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_level_valid", int'(level_valid), 0);
        push_exp(0, 0, 0);
        send_window(8);

        // no PDM clock: nothing moves
        repeat (300) @(negedge clk);
        chk("noclk_level", int'(level), 0);

        // randomized windows against the episode model
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                enable_mike = 1'b0;
                repeat ($urandom_range(1, 6)) @(negedge clk);
                enable_mike = 1'b1;
                model_clear();
            end
            r = $urandom_range(0, 3);
            case (r)
                0: n = 8 + $urandom_range(0, 4) - 2;
                1: n = ($urandom_range(0, 1) == 1) ? $urandom_range(13, 16) : $urandom_range(0, 3);
                2: n = $urandom_range(0, 16);
                default: n = 8;
            endcase
            model_window(n);
            send_window(n);
        end

        repeat (20) @(negedge clk);
        chk("pending_expectations", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
